// File: rtl/mips_branch_ctrl.sv
// Branch-path sequencer: fetch/decode, ALU flag capture, and one-cycle branch-type
// strobes for the downstream branch-condition block. All outputs are registered.
module mips_branch_ctrl #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic [5:0]  OPCODE,
  input  logic [4:0]  RT,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_VALID,
  output logic        IR_WR,
  output logic        PC_EN,
  output logic        NF,
  output logic        ZF,
  output logic        BLTZ,
  output logic        BGTZ,
  output logic        BLEZ,
  output logic        BNE,
  output logic        BEQ,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_RESOLVE
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,
    C_BEQ,
    C_BNE,
    C_BLEZ,
    C_BGTZ,
    C_BLTZ,
    C_JUMP
  } cls_t;

  state_t     state, nxt;
  cls_t       cls, cls_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       nf_nxt, zf_nxt, err_nxt;

  always_comb begin
    nxt     = state;
    cls_nxt = cls;
    cnt_nxt = cnt;
    nf_nxt  = NF;
    zf_nxt  = ZF;
    err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN) nxt = S_FETCH;
      end
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          6'b000100:           cls_nxt = C_BEQ;
          6'b000101:           cls_nxt = C_BNE;
          6'b000110:           cls_nxt = C_BLEZ;
          6'b000111:           cls_nxt = C_BGTZ;
          6'b000001:           cls_nxt = (RT == 5'd0) ? C_BLTZ : C_NONE;
          6'b000010, 6'b000011: cls_nxt = C_JUMP;
          default:             cls_nxt = C_NONE;
        endcase
        cnt_nxt = '0;
        nxt     = (cls_nxt == C_JUMP) ? S_RESOLVE : S_EXEC;
      end
      S_EXEC: begin
        if (ALU_VALID) begin
          nf_nxt = ALU_RESULT[31];
          zf_nxt = (ALU_RESULT == '0);
          if (cls != C_NONE) nxt = S_RESOLVE;
          else               nxt = RUN ? S_FETCH : S_IDLE;
        end else if (cnt == 8'(ALU_TIMEOUT)) begin
          // Last wait cycle expired: abandon the instruction, flags untouched.
          err_nxt = 1'b1;
          nxt     = RUN ? S_FETCH : S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_RESOLVE: nxt = RUN ? S_FETCH : S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cls   <= C_NONE;
      cnt   <= '0;
      NF    <= 1'b0;
      ZF    <= 1'b0;
      IR_WR <= 1'b0;
      PC_EN <= 1'b0;
      BLTZ  <= 1'b0;
      BGTZ  <= 1'b0;
      BLEZ  <= 1'b0;
      BNE   <= 1'b0;
      BEQ   <= 1'b0;
      BUSY  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= nxt;
      cls   <= cls_nxt;
      cnt   <= cnt_nxt;
      NF    <= nf_nxt;
      ZF    <= zf_nxt;
      IR_WR <= (nxt == S_FETCH);
      PC_EN <= (nxt == S_FETCH) || ((nxt == S_RESOLVE) && (cls_nxt == C_JUMP));
      BLTZ  <= (nxt == S_RESOLVE) && (cls_nxt == C_BLTZ);
      BGTZ  <= (nxt == S_RESOLVE) && (cls_nxt == C_BGTZ);
      BLEZ  <= (nxt == S_RESOLVE) && (cls_nxt == C_BLEZ);
      BNE   <= (nxt == S_RESOLVE) && (cls_nxt == C_BNE);
      BEQ   <= (nxt == S_RESOLVE) && (cls_nxt == C_BEQ);
      BUSY  <= (nxt != S_IDLE);
      ERR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mips_branch_ctrl.sv
// Directed bench for mips_branch_ctrl; output vector order is
// {IR_WR,PC_EN, NF,ZF, BLTZ,BGTZ,BLEZ,BNE,BEQ, BUSY,ERR}.
module tb_mips_branch_ctrl;

  logic        CLK = 1'b0;
  logic        RST, RUN, ALU_VALID;
  logic [5:0]  OPCODE;
  logic [4:0]  RT;
  logic [31:0] ALU_RESULT;
  logic        IR_WR, PC_EN, NF, ZF, BLTZ, BGTZ, BLEZ, BNE, BEQ, BUSY, ERR;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mips_branch_ctrl #(.ALU_TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .OPCODE(OPCODE), .RT(RT),
    .ALU_RESULT(ALU_RESULT), .ALU_VALID(ALU_VALID),
    .IR_WR(IR_WR), .PC_EN(PC_EN), .NF(NF), .ZF(ZF),
    .BLTZ(BLTZ), .BGTZ(BGTZ), .BLEZ(BLEZ), .BNE(BNE), .BEQ(BEQ),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b", tag, got[10:0], exp[10:0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [10:0] exp);
    check(tag, {21'b0, IR_WR, PC_EN, NF, ZF, BLTZ, BGTZ, BLEZ, BNE, BEQ, BUSY, ERR},
          {21'b0, exp});
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b1; ALU_VALID = 1'b0;
    OPCODE = '0; RT = '0; ALU_RESULT = '0;

    step; expect_out("reset1", 11'b00_00_00000_00);
    step; expect_out("reset2", 11'b00_00_00000_00);
    RST = 1'b0;
    #1 expect_out("idle_after_reset", 11'b00_00_00000_00);

    // BEQ, result zero
    step; expect_out("beq_fetch", 11'b11_00_00000_10);
    OPCODE = 6'b000100; RT = 5'd0;
    step; expect_out("beq_decode", 11'b00_00_00000_10);
    ALU_VALID = 1'b1; ALU_RESULT = 32'h0;
    step; expect_out("beq_exec", 11'b00_00_00000_10);
    step; expect_out("beq_resolve", 11'b00_01_00001_10);
    ALU_VALID = 1'b0;

    // BLTZ, negative result
    OPCODE = 6'b000001; RT = 5'd0;
    step; expect_out("bltz_fetch", 11'b11_01_00000_10);
    step; expect_out("bltz_decode", 11'b00_01_00000_10);
    ALU_VALID = 1'b1; ALU_RESULT = 32'hFFFF_FFF0;
    step; expect_out("bltz_exec", 11'b00_01_00000_10);
    step; expect_out("bltz_resolve", 11'b00_10_10000_10);
    ALU_VALID = 1'b0;

    // REGIMM with RT!=0 is a non-branch: EXEC then straight to FETCH
    RT = 5'd1;
    step; expect_out("regimm_fetch", 11'b11_10_00000_10);
    step; expect_out("regimm_decode", 11'b00_10_00000_10);
    ALU_VALID = 1'b1; ALU_RESULT = 32'h0;
    step; expect_out("regimm_exec", 11'b00_10_00000_10);
    step; expect_out("regimm_next_fetch", 11'b11_01_00000_10);
    ALU_VALID = 1'b0;

    // Jump: RESOLVE straight after DECODE, stray ALU_VALID ignored
    OPCODE = 6'b000010; RT = 5'd0;
    step; expect_out("jump_decode", 11'b00_01_00000_10);
    ALU_VALID = 1'b1; ALU_RESULT = 32'h8000_0000;
    step; expect_out("jump_resolve", 11'b01_01_00000_10);
    step; expect_out("jump_next_fetch", 11'b11_01_00000_10);
    ALU_VALID = 1'b0;

    // BNE with ALU never valid: timeout after 16 EXEC cycles
    OPCODE = 6'b000101;
    step; expect_out("bne_decode", 11'b00_01_00000_10);
    for (int i = 0; i < 16; i++) begin
      step; expect_out($sformatf("bne_exec_wait%0d", i), 11'b00_01_00000_10);
    end
    step; expect_out("bne_timeout_err", 11'b11_01_00000_11);

    // BGTZ, reset during RESOLVE
    OPCODE = 6'b000111;
    step; expect_out("bgtz_decode", 11'b00_01_00000_10);
    ALU_VALID = 1'b1; ALU_RESULT = 32'd5;
    step; expect_out("bgtz_exec", 11'b00_01_00000_10);
    step; expect_out("bgtz_resolve", 11'b00_00_01000_10);
    ALU_VALID = 1'b0; RST = 1'b1;
    step; expect_out("bgtz_reset", 11'b00_00_00000_00);
    RST = 1'b0;

    // BLEZ, RUN dropped during EXEC: strobe still issues, then IDLE
    step; expect_out("blez_fetch", 11'b11_00_00000_10);
    OPCODE = 6'b000110;
    step; expect_out("blez_decode", 11'b00_00_00000_10);
    step; expect_out("blez_exec", 11'b00_00_00000_10);
    RUN = 1'b0; ALU_VALID = 1'b1; ALU_RESULT = 32'h8000_0000;
    step; expect_out("blez_resolve", 11'b00_10_00100_10);
    ALU_VALID = 1'b0;
    step; expect_out("blez_idle", 11'b00_10_00000_00);
    step; expect_out("blez_idle_hold", 11'b00_10_00000_00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
